// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified instruction/data memory between the
// instruction-fetch requester and the load/store requester. Each access is
// one req/ack transaction. Data requests win over fetch requests, except that
// fetch is forced through after STARVE_MAX data grants made while fetch was
// waiting. A transaction that gets no mem_ready within TIMEOUT busy cycles is
// aborted and reported through err.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   i_req/i_addr             fetch request and byte address (held until i_ack)
//   i_ack/i_rdata            fetch completion pulse and fetched word
//   d_req/d_we/d_addr/
//   d_wdata/d_be             data request, store flag, address, data, enables
//   d_ack/d_rdata            data completion pulse and load data
//   err                      timeout pulse, coincident with the owner's ack
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be         memory command, held for the whole transaction
//   mem_ready/mem_rdata      memory completion and read data
//
// Timing: the grant edge latches the command and raises mem_req. The edge at
// which mem_ready is seen (or the timeout expires) drops mem_req and raises
// the owner's ack for one cycle. That ack cycle is an IDLE cycle, so a request
// still high at its closing edge is arbitrated as a new request.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  // Instruction-fetch requester
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic             i_ack,
  output logic [WIDTH-1:0] i_rdata,
  // Load/store requester
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  input  logic [3:0]       d_be,
  output logic             d_ack,
  output logic [WIDTH-1:0] d_rdata,
  output logic             err,
  // Memory side
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int TMO_W = $clog2(TIMEOUT);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
  localparam logic [STV_W-1:0] STV_SAT   = STV_W'(STARVE_MAX);
  localparam logic [STV_W-1:0] STV_ONE   = STV_W'(1);
  // Clears the byte offset; masking keeps every address bit in use.
  localparam logic [WIDTH-1:0] WORD_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IBUS = 2'd1,
    ST_DBUS = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [TMO_W-1:0] r_tmo_cnt;
  logic [STV_W-1:0] r_starve_cnt;

  logic             r_mem_req;
  logic             r_mem_we;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;
  logic [3:0]       r_mem_be;
  logic             r_i_ack;
  logic             r_d_ack;
  logic             r_err;
  logic [WIDTH-1:0] r_i_rdata;
  logic [WIDTH-1:0] r_d_rdata;

  logic w_grant_i;
  logic w_grant_d;
  logic w_done;
  logic w_timeout;

  // -------------------------------------------------------------------------
  // Next-state and event decode
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned; a missing default would infer a latch.
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Fetch only wins when data is absent or fetch has starved long enough.
        if (i_req && (!d_req || (r_starve_cnt == STV_SAT))) begin
          w_grant_i   = 1'b1;
          w_state_nxt = ST_IBUS;
        end else if (d_req) begin
          w_grant_d   = 1'b1;
          w_state_nxt = ST_DBUS;
        end
      end
      ST_IBUS, ST_DBUS: begin
        // A ready on the last allowed cycle still counts as a normal finish.
        if (mem_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Command latch, counters and completion outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tmo_cnt    <= '0;
      r_starve_cnt <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
      r_i_ack      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_err        <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      // Acks and err are single-cycle pulses.
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      r_err   <= 1'b0;

      if (w_grant_i) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= 1'b0;
        r_mem_addr   <= i_addr & WORD_MASK;
        r_mem_wdata  <= '0;
        r_mem_be     <= 4'b1111;
        r_tmo_cnt    <= '0;
        r_starve_cnt <= '0;
      end else if (w_grant_d) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= d_we;
        r_mem_addr  <= d_addr & WORD_MASK;
        r_mem_wdata <= d_wdata;
        r_mem_be    <= d_be;
        r_tmo_cnt   <= '0;
        // Only grants that overtake a waiting fetch count toward starvation.
        if (i_req && (r_starve_cnt != STV_SAT)) begin
          r_starve_cnt <= r_starve_cnt + STV_ONE;
        end
      end else if (w_done || w_timeout) begin
        r_mem_req <= 1'b0;
        r_err     <= w_timeout;
        if (r_state == ST_IBUS) begin
          r_i_ack   <= 1'b1;
          r_i_rdata <= w_done ? mem_rdata : '0;
        end else begin
          r_d_ack <= 1'b1;
          if (w_timeout) begin
            r_d_rdata <= '0;
          end else if (!r_mem_we) begin
            r_d_rdata <= mem_rdata;
          end
        end
      end else if (r_state != ST_IDLE) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
      end
    end
  end

  assign i_ack     = r_i_ack;
  assign i_rdata   = r_i_rdata;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign err       = r_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A transaction-level reference model
// tracks the owner of the memory, how many busy cycles it has used and how
// many data grants have overtaken a waiting fetch, and predicts every output;
// a compare process checks the DUT against it on each falling edge. Directed
// scenarios add hand-computed literal expectations. Inputs change on the
// falling edge; the DUT and the model sample them on the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int W    = 32;
  localparam int TMO  = 16;
  localparam int SMAX = 4;

  typedef enum int {OWN_NONE, OWN_FETCH, OWN_DATA} owner_e;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0;
  logic [W-1:0]  i_addr = '0;
  logic          i_ack;
  logic [W-1:0]  i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [W-1:0]  d_addr = '0;
  logic [W-1:0]  d_wdata = '0;
  logic [3:0]    d_be = '0;
  logic          d_ack;
  logic [W-1:0]  d_rdata;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [W-1:0]  mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ready = 1'b0;
  logic [W-1:0]  mem_rdata = '0;

  mem_port_arbiter #(
    .WIDTH     (W),
    .TIMEOUT   (TMO),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .err      (err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  initial forever #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Scoreboard counters and check task
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Memory responder: mem_ready on the rsp_lat-th busy cycle (0 = never)
  // -------------------------------------------------------------------------
  int          rsp_lat     = 1;
  bit          use_fixed   = 1'b0;
  logic [31:0] rsp_fixed   = '0;
  bit          force_ready = 1'b0;
  int          rsp_cnt     = 0;

  initial forever begin
    @(negedge clk);
    if (mem_req === 1'b1) rsp_cnt++;
    else rsp_cnt = 0;
    mem_ready = force_ready || ((mem_req === 1'b1) && (rsp_lat != 0) && (rsp_cnt == rsp_lat));
    mem_rdata = use_fixed ? rsp_fixed : {8'hA5, mem_addr[23:0]};
  end

  // -------------------------------------------------------------------------
  // Reference model: one transaction at a time, tracked by owner and age
  // -------------------------------------------------------------------------
  bit          m_valid = 1'b0;
  bit          m_fresh = 1'b0;
  owner_e      m_owner = OWN_NONE;
  int          m_age   = 0;
  int          m_starve = 0;
  bit          m_ok;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        e_i_ack, e_d_ack, e_err;
  logic [31:0] e_i_rdata, e_d_rdata;

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      m_valid   = 1'b1;
      m_fresh   = 1'b1;
      m_owner   = OWN_NONE;
      m_age     = 0;
      m_starve  = 0;
      m_we      = 1'b0;
      m_addr    = '0;
      m_wdata   = '0;
      m_be      = '0;
      e_i_ack   = 1'b0;
      e_d_ack   = 1'b0;
      e_err     = 1'b0;
      e_i_rdata = '0;
      e_d_rdata = '0;
    end else if (m_valid) begin
      e_i_ack = 1'b0;
      e_d_ack = 1'b0;
      e_err   = 1'b0;
      if (m_owner == OWN_NONE) begin
        if (i_req && (!d_req || m_starve == SMAX)) begin
          m_owner  = OWN_FETCH;
          m_age    = 0;
          m_fresh  = 1'b0;
          m_addr   = {i_addr[31:2], 2'b00};
          m_we     = 1'b0;
          m_be     = 4'hF;
          m_wdata  = '0;
          m_starve = 0;
        end else if (d_req) begin
          m_owner = OWN_DATA;
          m_age   = 0;
          m_fresh = 1'b0;
          m_addr  = {d_addr[31:2], 2'b00};
          m_we    = d_we;
          m_be    = d_be;
          m_wdata = d_wdata;
          if (i_req) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
        end
      end else begin
        m_age++;
        if (mem_ready || m_age == TMO) begin
          m_ok  = mem_ready;
          e_err = !m_ok;
          if (m_owner == OWN_FETCH) begin
            e_i_ack   = 1'b1;
            e_i_rdata = m_ok ? mem_rdata : 32'h0;
          end else begin
            e_d_ack = 1'b1;
            if (!m_ok) e_d_rdata = 32'h0;
            else if (!m_we) e_d_rdata = mem_rdata;
          end
          m_owner = OWN_NONE;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Cycle-by-cycle compare against the model
  // -------------------------------------------------------------------------
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("i_ack",   i_ack,   e_i_ack);
      check("d_ack",   d_ack,   e_d_ack);
      check("err",     err,     e_err);
      check("mem_req", mem_req, (m_owner != OWN_NONE));
      check("i_rdata", i_rdata, e_i_rdata);
      check("d_rdata", d_rdata, e_d_rdata);
      if (m_owner != OWN_NONE || m_fresh) begin
        check("mem_we",    mem_we,    m_we);
        check("mem_addr",  mem_addr,  m_addr);
        check("mem_be",    mem_be,    m_be);
        check("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  int          cap_busy;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  // Waits for the chosen ack, recording the memory command seen while busy.
  task automatic wait_ack(input bit want_fetch, input int max_cyc, output bit got);
    got      = 1'b0;
    cap_busy = 0;
    for (int c = 0; c < max_cyc && !got; c++) begin
      @(negedge clk);
      if (mem_req) begin
        cap_busy++;
        cap_we    = mem_we;
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
        cap_be    = mem_be;
      end
      if (want_fetch ? i_ack : d_ack) got = 1'b1;
    end
    if (!got) check(want_fetch ? "i_ack_wait" : "d_ack_wait", 0, 1);
  endtask

  task automatic wait_mem_req(input int max_cyc, output bit got);
    got = 1'b0;
    for (int c = 0; c < max_cyc && !got; c++) begin
      @(negedge clk);
      if (mem_req) got = 1'b1;
    end
    if (!got) check("mem_req_wait", 0, 1);
  endtask

  // -------------------------------------------------------------------------
  // Directed scenarios
  // -------------------------------------------------------------------------
  bit          got;
  byte         order_q[$];
  string       exp_order = "DDDDIDDDDI";
  logic [31:0] b2b_exp [4] = '{32'hA500_0100, 32'hA500_0104, 32'hA500_0108, 32'hA500_010C};
  int          ack_cnt;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_d_rdata", d_rdata, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single load with mem_ready on the second busy cycle
    rsp_lat = 2; use_fixed = 1'b1; rsp_fixed = 32'hDEAD_BEEF;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h103; d_be = 4'hF; d_wdata = 32'h5555_AAAA;
    wait_ack(1'b0, 10, got);
    d_req = 1'b0;
    check("load_busy_cycles", cap_busy, 2);
    check("load_mem_addr", cap_addr, 32'h100);
    check("load_mem_be", cap_be, 4'hF);
    check("load_mem_we", cap_we, 0);
    check("load_d_rdata", d_rdata, 32'hDEAD_BEEF);
    check("load_err", err, 0);

    // Store leaves d_rdata unchanged and acks once
    rsp_lat = 1; rsp_fixed = 32'h0BAD_0BAD;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678; d_be = 4'b0011;
    wait_ack(1'b0, 10, got);
    d_req = 1'b0; d_we = 1'b0;
    check("store_mem_we", cap_we, 1);
    check("store_mem_be", cap_be, 4'b0011);
    check("store_mem_wdata", cap_wdata, 32'h1234_5678);
    check("store_mem_addr", cap_addr, 32'h20);
    check("store_d_rdata", d_rdata, 32'hDEAD_BEEF);
    ack_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (d_ack) ack_cnt++;
    end
    check("store_extra_acks", ack_cnt, 0);

    // mem_ready is ignored while idle
    force_ready = 1'b1;
    ack_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (i_ack || d_ack) ack_cnt++;
    end
    force_ready = 1'b0;
    check("idle_ready_acks", ack_cnt, 0);
    @(negedge clk);

    // Contention: both held, immediate ready
    use_fixed = 1'b0; rsp_lat = 1;
    @(negedge clk);
    i_addr = 32'h400; d_addr = 32'h800; d_we = 1'b0; d_be = 4'hF;
    i_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 60 && order_q.size() < 10; c++) begin
      @(negedge clk);
      if (i_ack && d_ack) check("double_ack", 1, 0);
      if (i_ack) order_q.push_back("I");
      if (d_ack) order_q.push_back("D");
    end
    i_req = 1'b0; d_req = 1'b0;
    check("order_len", order_q.size(), 10);
    for (int k = 0; k < 10 && k < order_q.size(); k++) check("grant_order", order_q[k], exp_order[k]);
    check("contention_i_rdata", i_rdata, 32'hA500_0400);
    @(negedge clk);

    // Timeout on a fetch
    rsp_lat = 0;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h44;
    wait_ack(1'b1, 40, got);
    i_req = 1'b0;
    check("tmo_busy_cycles", cap_busy, 16);
    check("tmo_err", err, 1);
    check("tmo_i_rdata", i_rdata, 0);
    check("tmo_mem_req", mem_req, 0);
    @(negedge clk);
    check("tmo_err_clear", err, 0);
    check("tmo_mem_req_next", mem_req, 0);

    // Reset in the middle of a data transaction
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
    wait_mem_req(5, got);
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("mid_rst_mem_req", mem_req, 0);
    check("mid_rst_d_ack", d_ack, 0);
    check("mid_rst_d_rdata", d_rdata, 0);
    check("mid_rst_i_rdata", i_rdata, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    rst = 1'b1;
    ack_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (d_ack) ack_cnt++;
    end
    check("post_rst_no_d_ack", ack_cnt, 0);
    rsp_lat = 1;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h8A;
    wait_ack(1'b1, 10, got);
    i_req = 1'b0;
    check("post_rst_i_rdata", i_rdata, 32'hA500_0088);

    // Data request withdrawn after its grant still completes
    rsp_lat = 3;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hCAFE_F00D; d_be = 4'b1100;
    wait_mem_req(5, got);
    d_req = 1'b0;
    wait_ack(1'b0, 10, got);
    check("withdraw_ack", got, 1);
    d_we = 1'b0;

    // Back-to-back fetches, address advanced on each ack cycle
    rsp_lat = 1;
    @(negedge clk);
    i_addr = 32'h100; i_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(1'b1, 10, got);
      check("b2b_i_rdata", i_rdata, b2b_exp[k]);
      i_addr = i_addr + 32'd4;
      if (k == 3) i_req = 1'b0;
    end
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
